// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if
// Bundles the start/busy/done handshake, the packed BCD operand and the
// conversion results of bcd_to_bin_seq into a single port.
//
// Signals:
//   start    master -> slave  request a conversion (sampled only when idle)
//   bcd_in   master -> slave  packed BCD operand, digit i at [4i+3:4i]
//   busy     slave -> master  conversion in progress
//   done     slave -> master  one-cycle pulse when results are updated
//   bin_out  slave -> master  binary result, held until the next done
//   err      slave -> master  last request contained a digit above 9
//   ovf      slave -> master  last value did not fit in BIN_W bits
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;
    logic                  ovf;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err, ovf
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err, ovf
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
// Sequential BCD-to-binary converter (reverse double dabble). The operand is
// placed in the upper half of a {bcd, bin} shift register; each clock shifts
// the whole register right by one and then pulls 3 out of every BCD digit that
// landed at 8 or above. After BIN_W shifts the low half holds the binary value
// and anything left in the BCD half means the value did not fit.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any conversion, no done)
//   bus    bcd_to_bin_seq_if.slave: start, bcd_in in; busy, done, bin_out,
//          err, ovf out
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_to_bin_seq_if.slave   bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SHIFT,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [BCD_W-1:0]      bcd_r, bcd_next;
    logic [BIN_W-1:0]      bin_r, bin_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [BIN_W-1:0]      bin_out_r, bin_out_next;
    logic                  err_r, err_next;
    logic                  ovf_r, ovf_next;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       corrected;
    logic                   any_bad;

    // A digit that reached 8..12 after a shift had a ten's worth of weight
    // pushed into it as eight; removing 3 restores the correct BCD value.
    function automatic logic [3:0] fix_digit(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    // Datapath helpers: the shifted register image, its per-digit correction,
    // and the invalid-digit detector used while in CHECK.
    always_comb begin
        shifted   = {bcd_r, bin_r} >> 1;
        corrected = '0;
        any_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            corrected[4*i +: 4] = fix_digit(shifted[BIN_W + 4*i +: 4]);
            if (bcd_r[4*i +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end

    // Next-state and next-register logic. Result registers only receive new
    // values on the transition into DONE, so they hold between conversions.
    always_comb begin
        state_next   = state;
        bcd_next     = bcd_r;
        bin_next     = bin_r;
        cnt_next     = cnt;
        bin_out_next = bin_out_r;
        err_next     = err_r;
        ovf_next     = ovf_r;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    bcd_next   = bus.bcd_in;
                    bin_next   = '0;
                    cnt_next   = '0;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (any_bad) begin
                    bin_out_next = '0;
                    err_next     = 1'b1;
                    ovf_next     = 1'b0;
                    state_next   = DONE;
                end else begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                bcd_next = corrected;
                bin_next = shifted[BIN_W-1:0];
                cnt_next = cnt + CNT_W'(1);
                // cnt still holds the pre-increment value, so this is the
                // BIN_W-th shift.
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    bin_out_next = shifted[BIN_W-1:0];
                    err_next     = 1'b0;
                    ovf_next     = |corrected;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, working registers and result registers; reset wipes everything
    // including any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcd_r     <= '0;
            bin_r     <= '0;
            cnt       <= '0;
            bin_out_r <= '0;
            err_r     <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state     <= state_next;
            bcd_r     <= bcd_next;
            bin_r     <= bin_next;
            cnt       <= cnt_next;
            bin_out_r <= bin_out_next;
            err_r     <= err_next;
            ovf_r     <= ovf_next;
        end
    end

    // Handshake flags decode straight from the registered state.
    assign bus.busy    = (state == CHECK) || (state == SHIFT);
    assign bus.done    = (state == DONE);
    assign bus.bin_out = bin_out_r;
    assign bus.err     = err_r;
    assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq
// Drives two converters from the same stimulus: the default build (3 digits,
// 10-bit result) and a narrow build (3 digits, 8-bit result) that exercises
// the overflow path. Expected results come from a decimal-arithmetic model.
module tb_bcd_to_bin_seq;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    logic [9:0] last_bin;
    logic [7:0] last_bin8;
    bit         last_bin8_known;

    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();
    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(8))  bus8 ();

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    // 100 MHz clock and a free-running cycle counter for timing checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something waits forever despite the loop bounds.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        string      name;
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        err;
        logic        ovf;
        logic [7:0]  bin8;
        logic        ovf8;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [11:0] b);
        bus.start   = s;
        bus.bcd_in  = b;
        bus8.start  = s;
        bus8.bcd_in = b;
    endtask

    // Decimal model: value of the digits, mod 2^w, overflow when >= 2^w.
    function automatic void ref_model(input logic [11:0] bcd, input int w,
                                      output logic [31:0] bin, output logic err,
                                      output logic ovf);
        int v;
        int d;
        err = 1'b0;
        v   = 0;
        for (int i = 2; i >= 0; i--) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) err = 1'b1;
            v = v * 10 + d;
        end
        if (err) begin
            bin = 0;
            ovf = 1'b0;
        end else begin
            bin = v % (1 << w);
            ovf = (v >= (1 << w));
        end
    endfunction

    // One request on both converters; checks latency, busy length, single
    // done pulse, results, and that bcd_in is only sampled at capture.
    task automatic applyStimulus(input string name, input logic [11:0] bcd,
                                 input logic [9:0] e_bin, input logic e_err, input logic e_ovf,
                                 input logic [7:0] e_bin8, input logic e_ovf8);
        int lat, lat8, busy_cnt, busy_cnt8, done_cnt, done_cnt8, n;
        bit seen, seen8;
        logic [9:0] g_bin;
        logic [7:0] g_bin8;
        logic g_err, g_ovf, g_err8, g_ovf8;
        int exp_lat, exp_lat8;

        exp_lat  = e_err ? 1 : 11;
        exp_lat8 = e_err ? 1 : 9;
        lat = 0; lat8 = 0; busy_cnt = 0; busy_cnt8 = 0; done_cnt = 0; done_cnt8 = 0;
        seen = 0; seen8 = 0; n = 0;
        g_bin = '0; g_bin8 = '0; g_err = 0; g_ovf = 0; g_err8 = 0; g_ovf8 = 0;

        @(posedge clk); #1 drive(1'b1, bcd);
        @(posedge clk); #1 drive(1'b0, 12'($urandom));
        @(negedge clk);
        checkOutput({name, " hold bin_out"}, 32'(bus.bin_out), 32'(last_bin));
        if (last_bin8_known) checkOutput({name, " hold bin_out8"}, 32'(bus8.bin_out), 32'(last_bin8));

        while (!(seen && seen8) && n < 40) begin
            if (!seen && bus.busy) busy_cnt++;
            if (!seen8 && bus8.busy) busy_cnt8++;
            @(posedge clk); n++;
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (!seen) begin
                    seen = 1; lat = n;
                    g_bin = bus.bin_out; g_err = bus.err; g_ovf = bus.ovf;
                    checkOutput({name, " busy in done"}, 32'(bus.busy), 32'd0);
                end
            end
            if (bus8.done) begin
                done_cnt8++;
                if (!seen8) begin
                    seen8 = 1; lat8 = n;
                    g_bin8 = bus8.bin_out; g_err8 = bus8.err; g_ovf8 = bus8.ovf;
                end
            end
        end
        @(posedge clk); @(negedge clk);
        if (bus.done) done_cnt++;
        if (bus8.done) done_cnt8++;

        checkOutput({name, " completed"}, 32'(seen && seen8), 32'd1);
        checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
        checkOutput({name, " done pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({name, " bin_out"}, 32'(g_bin), 32'(e_bin));
        checkOutput({name, " err"}, 32'(g_err), 32'(e_err));
        checkOutput({name, " ovf"}, 32'(g_ovf), 32'(e_ovf));
        checkOutput({name, " latency8"}, 32'(lat8), 32'(exp_lat8));
        checkOutput({name, " busy cycles8"}, 32'(busy_cnt8), 32'(exp_lat8));
        checkOutput({name, " done pulses8"}, 32'(done_cnt8), 32'd1);
        checkOutput({name, " bin_out8"}, 32'(g_bin8), 32'(e_bin8));
        checkOutput({name, " err8"}, 32'(g_err8), 32'(e_err));
        checkOutput({name, " ovf8"}, 32'(g_ovf8), 32'(e_ovf8));
        checkOutput({name, " bin_out after done"}, 32'(bus.bin_out), 32'(e_bin));

        last_bin        = e_bin;
        last_bin8       = e_bin8;
        last_bin8_known = 1;
    endtask

    initial begin
        vec_t vecs[$];
        logic [31:0] m_bin, m_bin8;
        logic m_err, m_ovf, m_err8, m_ovf8;
        logic [11:0] r_bcd;
        int done_at[3];
        logic [9:0] bin_at[3];
        int k, n, spurious;

        checks = 0; errors = 0; cyc = 0;
        last_bin = '0; last_bin8 = '0; last_bin8_known = 1;
        rst_n = 1'b0;
        drive(1'b0, 12'h000);

        // Reset held with random inputs: every output must stay at zero.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 drive(1'($urandom), 12'($urandom));
            @(negedge clk);
            checkOutput("reset outputs", {bus.busy, bus.done, bus.err, bus.ovf, 18'd0, bus.bin_out}, 32'd0);
            checkOutput("reset outputs8", {bus8.busy, bus8.done, bus8.err, bus8.ovf, 20'd0, bus8.bin_out}, 32'd0);
        end
        @(posedge clk); #1 drive(1'b0, 12'h000);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus8.done || bus8.busy) spurious++;
        end
        checkOutput("idle after reset", 32'(spurious), 32'd0);

        // Directed table: fields are 10-bit result, then 8-bit result.
        vecs.push_back('{"v255", 12'h255, 10'd255, 1'b0, 1'b0, 8'd255, 1'b0});
        vecs.push_back('{"v000", 12'h000, 10'd0,   1'b0, 1'b0, 8'd0,   1'b0});
        vecs.push_back('{"v999", 12'h999, 10'd999, 1'b0, 1'b0, 8'd231, 1'b1});
        vecs.push_back('{"v1A3", 12'h1A3, 10'd0,   1'b1, 1'b0, 8'd0,   1'b0});
        vecs.push_back('{"v042", 12'h042, 10'd42,  1'b0, 1'b0, 8'd42,  1'b0});
        vecs.push_back('{"v300", 12'h300, 10'd300, 1'b0, 1'b0, 8'd44,  1'b1});
        vecs.push_back('{"v256", 12'h256, 10'd256, 1'b0, 1'b0, 8'd0,   1'b1});
        vecs.push_back('{"v9F9", 12'h9F9, 10'd0,   1'b1, 1'b0, 8'd0,   1'b0});
        vecs.push_back('{"v010", 12'h010, 10'd10,  1'b0, 1'b0, 8'd10,  1'b0});
        vecs.push_back('{"vF00", 12'hF00, 10'd0,   1'b1, 1'b0, 8'd0,   1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].name, vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].ovf,
                          vecs[i].bin8, vecs[i].ovf8);
        end

        // Random operands, mostly valid digits with the odd illegal one.
        for (int i = 0; i < 40; i++) begin
            r_bcd = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 11))};
            ref_model(r_bcd, 10, m_bin, m_err, m_ovf);
            ref_model(r_bcd, 8, m_bin8, m_err8, m_ovf8);
            applyStimulus("random", r_bcd, m_bin[9:0], m_err, m_ovf, m_bin8[7:0], m_ovf8);
        end

        // Start held high: back-to-back conversions every 13 cycles; the
        // operand change mid-shift only shows up in the following result.
        $display("[TB] held-start sequence");
        @(posedge clk); #1 drive(1'b1, 12'h123);
        k = 0; n = 0;
        while (k < 3 && n < 60) begin
            @(negedge clk); n++;
            if (bus.done) begin
                done_at[k] = cyc;
                bin_at[k]  = bus.bin_out;
                k++;
                if (k == 3) drive(1'b0, 12'h000);
            end else if (k == 1 && cyc == done_at[0] + 6) begin
                drive(1'b1, 12'h456);
            end
        end
        checkOutput("held start three dones", 32'(k), 32'd3);
        checkOutput("held start result 1", 32'(bin_at[0]), 32'd123);
        checkOutput("held start result 2", 32'(bin_at[1]), 32'd123);
        checkOutput("held start result 3", 32'(bin_at[2]), 32'd456);
        checkOutput("held start period 1", 32'(done_at[1] - done_at[0]), 32'd13);
        checkOutput("held start period 2", 32'(done_at[2] - done_at[1]), 32'd13);
        repeat (20) @(posedge clk);
        last_bin = 10'd456;
        last_bin8_known = 0;

        // Reset in the middle of a conversion: outputs clear at once and the
        // aborted request never produces done.
        applyStimulus("pre-abort v999", 12'h999, 10'd999, 1'b0, 1'b0, 8'd231, 1'b1);
        @(posedge clk); #1 drive(1'b1, 12'h777);
        @(posedge clk); #1 drive(1'b0, 12'h777);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort outputs", {bus.busy, bus.done, bus.err, bus.ovf, 18'd0, bus.bin_out}, 32'd0);
        checkOutput("abort outputs8", {bus8.busy, bus8.done, bus8.err, bus8.ovf, 20'd0, bus8.bin_out}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus8.done || bus8.busy) spurious++;
        end
        checkOutput("no done after abort", 32'(spurious), 32'd0);
        last_bin = '0; last_bin8 = '0; last_bin8_known = 1;
        applyStimulus("post-abort v500", 12'h500, 10'd500, 1'b0, 1'b0, 8'd244, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
